// File: rtl/fpga_mmio_panel.sv
// rtl/fpga_mmio_panel.sv - memory-mapped seven-segment, LED and pushbutton panel
// Debounced buttons raise sticky rise flags that clear when their PB_EDGE byte is read.
module fpga_mmio_panel #(
    parameter int NUM_DIGITS      = 8,
    parameter int NUM_LED_BYTES   = 2,
    parameter int NUM_PB          = 21,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       read_en,
    input  logic                       write_en,
    input  logic [7:0]                 addr,
    input  logic [7:0]                 din,
    input  logic [NUM_PB-1:0]          pb,
    output logic [7:0]                 dout,
    output logic [NUM_DIGITS*8-1:0]    ss,
    output logic [NUM_LED_BYTES*8-1:0] leds,
    output logic                       irq
);
    localparam int PBB = (NUM_PB + 7) / 8;
    localparam int PBW = PBB * 8;
    localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [7:0] A_MODE = 8'(NUM_DIGITS);
    localparam logic [7:0] A_LED  = 8'(NUM_DIGITS + 1);
    localparam logic [7:0] A_LVL  = 8'(NUM_DIGITS + NUM_LED_BYTES + 1);
    localparam logic [7:0] A_EDG  = 8'(NUM_DIGITS + NUM_LED_BYTES + 1 + PBB);

    logic [7:0]        digit [NUM_DIGITS];
    logic [7:0]        led   [NUM_LED_BYTES];
    logic [2:0]        mode;
    logic [NUM_PB-1:0] sync1, sync2, level, flags, flip, edge_clr;
    logic [CW-1:0]     cnt   [NUM_PB];
    logic [7:0]        rdata;
    logic [PBW-1:0]    lvl_pad, flg_pad;

    function automatic logic [7:0] glyph(input logic [7:0] v);
        case (v)
            8'd0:    glyph = 8'h3F;
            8'd1:    glyph = 8'h06;
            8'd2:    glyph = 8'h5B;
            8'd3:    glyph = 8'h4F;
            8'd4:    glyph = 8'h66;
            8'd5:    glyph = 8'h6D;
            8'd6:    glyph = 8'h7D;
            8'd7:    glyph = 8'h07;
            8'd8:    glyph = 8'h7F;
            8'd9:    glyph = 8'h6F;
            8'd10:   glyph = 8'h77;
            8'd11:   glyph = 8'h7C;
            8'd12:   glyph = 8'h39;
            8'd13:   glyph = 8'h5E;
            8'd14:   glyph = 8'h79;
            8'd15:   glyph = 8'h71;
            8'd16:   glyph = 8'h76;
            8'd17:   glyph = 8'h3E;
            8'd18:   glyph = 8'h5C;
            8'd19:   glyph = 8'h50;
            default: glyph = 8'h3F;
        endcase
    endfunction

    assign lvl_pad = PBW'(level);
    assign flg_pad = PBW'(flags);

    // flip marks the sample on which a button has disagreed long enough to be accepted
    always_comb begin
        flip     = '0;
        edge_clr = '0;
        for (int b = 0; b < NUM_PB; b++) begin
            flip[b]     = (sync2[b] != level[b]) && (cnt[b] == CW'(DEBOUNCE_CYCLES - 1));
            edge_clr[b] = read_en && (addr == A_EDG + 8'(b / 8));
        end
    end

    always_comb begin
        rdata = 8'h00;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (addr == 8'(i)) rdata = digit[i];
        if (addr == A_MODE) rdata = {5'b0, mode};
        for (int j = 0; j < NUM_LED_BYTES; j++)
            if (addr == A_LED + 8'(j)) rdata = led[j];
        for (int k = 0; k < PBB; k++) begin
            if (addr == A_LVL + 8'(k)) rdata = lvl_pad[8*k +: 8];
            if (addr == A_EDG + 8'(k)) rdata = flg_pad[8*k +: 8];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= 8'h00;
            for (int j = 0; j < NUM_LED_BYTES; j++) led[j] <= 8'h00;
            for (int b = 0; b < NUM_PB; b++) cnt[b] <= '0;
            mode  <= 3'b000;
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            flags <= '0;
            dout  <= 8'h00;
        end else begin
            if (read_en) dout <= rdata;
            if (write_en) begin
                for (int i = 0; i < NUM_DIGITS; i++)
                    if (addr == 8'(i)) digit[i] <= din;
                if (addr == A_MODE) mode <= din[2:0];
                for (int j = 0; j < NUM_LED_BYTES; j++)
                    if (addr == A_LED + 8'(j)) led[j] <= din;
            end
            sync1 <= pb;
            sync2 <= sync1;
            for (int b = 0; b < NUM_PB; b++) begin
                if (sync2[b] == level[b] || flip[b])
                    cnt[b] <= '0;
                else
                    cnt[b] <= cnt[b] + 1'b1;
            end
            level <= level ^ flip;
            // a rise coinciding with a clear survives; the read already captured the old bit
            flags <= (flags & ~edge_clr) | (flip & ~level);
        end
    end

    always_comb begin
        ss = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            ss[8*i +: 8] = mode[1] ? 8'h00 : (mode[0] ? digit[i] : glyph(digit[i]));
    end

    always_comb begin
        leds = '0;
        for (int j = 0; j < NUM_LED_BYTES; j++)
            leds[8*j +: 8] = led[j];
    end

    assign irq = mode[2] & (|flags);

endmodule

// File: tb/tb_fpga_mmio_panel.sv
// tb/tb_fpga_mmio_panel.sv - self-checking bench for fpga_mmio_panel
// Directed panel scenarios, then random bus/button traffic against a behavioural model.
module tb_fpga_mmio_panel;
    localparam int ND  = 8;
    localparam int NL  = 2;
    localparam int NP  = 21;
    localparam int DC  = 4;
    localparam int PBB = 3;
    localparam int A_LVL = ND + NL + 1;
    localparam int A_EDG = ND + NL + 1 + PBB;

    logic            clk = 1'b0;
    logic            nrst, read_en, write_en, irq;
    logic [7:0]      addr, din, dout;
    logic [NP-1:0]   pb;
    logic [ND*8-1:0] ss;
    logic [NL*8-1:0] leds;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]    m_digit [ND];
    logic [7:0]    m_led   [NL];
    logic [2:0]    m_mode;
    logic [NP-1:0] m_s1, m_s2, m_lvl, m_flag;
    int            m_run   [NP];
    logic [7:0]    m_dout;
    logic [7:0]    glyph_tab [20] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D,
                                      8'h07, 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E,
                                      8'h79, 8'h71, 8'h76, 8'h3E, 8'h5C, 8'h50};

    always #5 clk = ~clk;

    fpga_mmio_panel #(
        .NUM_DIGITS(ND), .NUM_LED_BYTES(NL), .NUM_PB(NP), .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk), .nrst(nrst), .read_en(read_en), .write_en(write_en),
        .addr(addr), .din(din), .pb(pb), .dout(dout), .ss(ss), .leds(leds), .irq(irq)
    );

    function automatic logic [7:0] m_read(input logic [7:0] a);
        int ai = int'(a);
        logic [31:0] p;
        if (ai < ND) return m_digit[ai];
        if (ai == ND) return {5'b0, m_mode};
        if (ai <= ND + NL) return m_led[ai - ND - 1];
        if (ai < A_EDG) begin
            p = 32'(m_lvl);
            return p[8*(ai - A_LVL) +: 8];
        end
        if (ai < A_EDG + PBB) begin
            p = 32'(m_flag);
            return p[8*(ai - A_EDG) +: 8];
        end
        return 8'h00;
    endfunction

    function automatic logic [ND*8-1:0] m_ss();
        logic [ND*8-1:0] r = '0;
        for (int i = 0; i < ND; i++) begin
            if (m_mode[1]) r[8*i +: 8] = 8'h00;
            else if (m_mode[0]) r[8*i +: 8] = m_digit[i];
            else r[8*i +: 8] = (m_digit[i] < 20) ? glyph_tab[m_digit[i]] : 8'h3F;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) m_digit[i] = 8'h00;
        for (int j = 0; j < NL; j++) m_led[j] = 8'h00;
        for (int b = 0; b < NP; b++) m_run[b] = 0;
        m_mode = 3'b000;
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_flag = '0;
        m_dout = 8'h00;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("ss", 64'(ss), 64'(m_ss()));
        check("leds", 64'(leds), 64'(m_led[1]) << 8 | 64'(m_led[0]));
        check("irq", 64'(irq), 64'(m_mode[2] & (|m_flag)));
        check("dout", 64'(dout), 64'(m_dout));
    endtask

    // one clock edge: advance the model on the inputs currently applied, then compare
    task automatic step();
        logic [7:0]    rd_v;
        logic [NP-1:0] rise, clr;
        int            ai;
        rd_v = m_read(addr);
        ai   = int'(addr);
        rise = '0;
        clr  = '0;
        for (int b = 0; b < NP; b++) begin
            if (m_s2[b] !== m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] == DC) begin
                    m_run[b] = 0;
                    m_lvl[b] = ~m_lvl[b];
                    rise[b]  = m_lvl[b];
                end
            end else begin
                m_run[b] = 0;
            end
            if (read_en && ai == A_EDG + b / 8) clr[b] = 1'b1;
        end
        m_flag = (m_flag & ~clr) | rise;
        m_s2 = m_s1;
        m_s1 = pb;
        if (read_en) m_dout = rd_v;
        if (write_en) begin
            if (ai < ND) m_digit[ai] = din;
            else if (ai == ND) m_mode = din[2:0];
            else if (ai <= ND + NL) m_led[ai - ND - 1] = din;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        addr = 8'(a); din = d; write_en = 1'b1;
        step();
        write_en = 1'b0;
    endtask

    task automatic rd(input int a);
        addr = 8'(a); read_en = 1'b1;
        step();
        read_en = 1'b0;
    endtask

    initial begin
        int op;
        nrst = 1'b0; read_en = 1'b0; write_en = 1'b0;
        addr = 8'h00; din = 8'h00; pb = '0;
        model_reset();
        #1;
        check("rst_ss", 64'(ss), {8{8'h3F}});
        check("rst_leds", 64'(leds), 64'h0);
        check("rst_irq", 64'(irq), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        check_all();
        nrst = 1'b1;

        rd(ND);
        check("mode_read", 64'(dout), 64'h00);
        wr(3, 8'h0B);
        check("glyph_b", 64'(ss[31:24]), 64'h7C);
        wr(ND, 8'h01);
        check("raw_mode", 64'(ss[31:24]), 64'h0B);
        wr(ND, 8'h03);
        check("blank", 64'(ss), 64'h0);
        rd(3);
        check("digit_read", 64'(dout), 64'h0B);

        wr(9, 8'hA5);
        wr(10, 8'h3C);
        wr(40, 8'hFF);
        check("leds_val", 64'(leds), 64'h3CA5);
        rd(40);
        check("unmapped_read", 64'(dout), 64'h00);

        pb[5] = 1'b1;
        repeat (5) rd(A_LVL);
        rd(A_LVL);
        check("lvl_before", 64'(dout), 64'h00);
        rd(A_LVL);
        check("lvl_after", 64'(dout), 64'h20);

        pb[6] = 1'b1;
        repeat (3) step();
        pb[6] = 1'b0;
        repeat (8) step();
        rd(A_LVL);
        check("glitch_lvl", 64'(dout), 64'h20);

        wr(ND, 8'h04);
        check("irq_set", 64'(irq), 64'h1);
        rd(A_EDG);
        check("edge_read", 64'(dout), 64'h20);
        check("irq_drop", 64'(irq), 64'h0);
        rd(A_EDG);
        check("edge_cleared", 64'(dout), 64'h00);

        pb[9] = 1'b1;
        repeat (5) step();
        rd(A_EDG + 1);
        check("coincide_rd", 64'(dout), 64'h00);
        check("coincide_irq", 64'(irq), 64'h1);
        rd(A_EDG + 1);
        check("coincide_next", 64'(dout), 64'h02);

        repeat (500) begin
            addr = ($urandom_range(0, 15) == 0) ? 8'd40 : 8'($urandom_range(0, 20));
            din  = 8'($urandom);
            op   = int'($urandom_range(0, 3));
            write_en = (op == 1 || op == 3);
            read_en  = (op == 2 || op == 3);
            if ($urandom_range(0, 5) == 0) pb = NP'($urandom);
            step();
            read_en = 1'b0; write_en = 1'b0;
        end

        wr(ND, 8'h04);
        pb = NP'($urandom) | NP'(1);
        repeat (4) step();
        nrst = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        nrst = 1'b1;
        check_all();
        repeat (8) step();
        for (int k = 0; k < PBB; k++) rd(A_LVL + k);
        for (int k = 0; k < PBB; k++) rd(A_EDG + k);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
